// File: rtl/ikaopll_pkg.sv
// Shared constants for the IKAOPLL timing generator: default divider and slot
// counts, decoded slot indices and the test-register bit that freezes the
// cycle counter.
package ikaopll_pkg;

  localparam int DIV_DEFAULT      = 4;
  localparam int NSLOT_DEFAULT    = 18;
  localparam int RST_HOLD_DEFAULT = 2;

  localparam int SLOT_00   = 0;
  localparam int SLOT_03   = 3;
  localparam int SLOT_04   = 4;
  localparam int SLOT_LAST = NSLOT_DEFAULT - 1;

  // i_TEST bit that holds the slot counter at 0
  localparam int TEST_CNTHOLD = 1;

  // width of the optional debug copy of the slot counter
  localparam int CYCLE_NUM_W = 5;

endpackage

// File: rtl/ikaopll_timinggen_if.sv
// Timing-generator signal bundle: test register in, phi1 enables, internal
// reset and cycle strobes out. The debug slot-count tap exists only when
// IKAOPLL_CYCLE_BUS_EN is defined.
interface ikaopll_timinggen_if;
  import ikaopll_pkg::*;

  logic [3:0] i_TEST;
  logic       o_phi1_PCEN_n;
  logic       o_phi1_NCEN_n;
  logic       o_RST_n;
  logic       o_CYCLE_00;
  logic       o_CYCLE_17;
  logic       o_CYCLE_D4;
  logic       o_CYCLE_D3_ZZ;
`ifdef IKAOPLL_CYCLE_BUS_EN
  logic [CYCLE_NUM_W-1:0] o_CYCLE_NUM;
`endif

  // timing generator side
  modport master (
    input  i_TEST,
    output o_phi1_PCEN_n,
    output o_phi1_NCEN_n,
    output o_RST_n,
    output o_CYCLE_00,
    output o_CYCLE_17,
    output o_CYCLE_D4,
    output o_CYCLE_D3_ZZ
`ifdef IKAOPLL_CYCLE_BUS_EN
    ,
    output o_CYCLE_NUM
`endif
  );

  // consumer side
  modport slave (
    output i_TEST,
    input  o_phi1_PCEN_n,
    input  o_phi1_NCEN_n,
    input  o_RST_n,
    input  o_CYCLE_00,
    input  o_CYCLE_17,
    input  o_CYCLE_D4,
    input  o_CYCLE_D3_ZZ
`ifdef IKAOPLL_CYCLE_BUS_EN
    ,
    input  o_CYCLE_NUM
`endif
  );

endinterface

// File: rtl/ikaopll_clkdiv.sv
// phi1 clock-enable generator: a modulo-DIV counter on the emulator clock
// producing one-emuclk active-low NCEN (mid-period) and PCEN (end of period)
// pulses. The two pulses sit half a phi1 period apart and never coincide.
module ikaopll_clkdiv #(
  parameter int DIV = 4
) (
  input  logic emuclk,
  input  logic rst,
  output logic pcen_n,
  output logic ncen_n
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] NCEN_AT = DW'(DIV / 2 - 1);
  localparam logic [DW-1:0] PCEN_AT = DW'(DIV - 1);

  logic [DW-1:0] div;

  // free-running divider, wraps after DIV-1
  always_ff @(posedge emuclk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == PCEN_AT) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // registered enables decoded from the divider phase
  always_ff @(posedge emuclk or posedge rst) begin
    if (rst) begin
      ncen_n <= 1'b1;
      pcen_n <= 1'b1;
    end else begin
      ncen_n <= (div != NCEN_AT);
      pcen_n <= (div != PCEN_AT);
    end
  end

endmodule

// File: rtl/ikaopll_timinggen.sv
// IKAOPLL master timing generator: phi1 enables (via ikaopll_clkdiv), the
// per-sample slot counter, cycle strobes for the LFO/EG/OP datapaths and the
// sample-aligned internal reset stretch.
// Optional feature macro: IKAOPLL_CYCLE_BUS_EN exposes the slot count on
// o_CYCLE_NUM for debug taps.
module ikaopll_timinggen
  import ikaopll_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int NSLOT    = NSLOT_DEFAULT,
  parameter int RST_HOLD = RST_HOLD_DEFAULT
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_RST,
  ikaopll_timinggen_if.master  tg
);

  localparam int SW = (NSLOT > 2) ? $clog2(NSLOT) : 1;
  localparam int HW = $clog2(RST_HOLD + 2);
  localparam logic [SW-1:0] S_00   = SW'(SLOT_00);
  localparam logic [SW-1:0] S_03   = SW'(SLOT_03);
  localparam logic [SW-1:0] S_04   = SW'(SLOT_04);
  localparam logic [SW-1:0] S_LAST = SW'(NSLOT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

  logic          pcen_n;
  logic          ncen_n;
  logic          cnt_hold;
  logic          unused_test_bits;

  logic [SW-1:0] slot;
  logic [SW-1:0] slot_next;
  logic          wrap;

  logic          cycle_00;
  logic          cycle_17;
  logic          cycle_d4;
  logic          cycle_d3;
  logic          cycle_d3_z;
  logic          cycle_d3_zz;

  logic [HW-1:0] hold;
  logic          rst_n;

  ikaopll_clkdiv #(
    .DIV (DIV)
  ) u_clkdiv (
    .emuclk (i_EMUCLK),
    .rst    (i_RST),
    .pcen_n (pcen_n),
    .ncen_n (ncen_n)
  );

  assign cnt_hold         = tg.i_TEST[TEST_CNTHOLD];
  assign unused_test_bits = ^{tg.i_TEST[3:2], tg.i_TEST[0]};

  // value the slot counter takes at the next NCEN; a test hold is not a wrap,
  // so it also freezes the reset-stretch counter
  always_comb begin
    slot_next = slot + SW'(1);
    wrap      = 1'b0;
    if (cnt_hold) begin
      slot_next = S_00;
    end else if (slot == S_LAST) begin
      slot_next = S_00;
      wrap      = 1'b1;
    end
  end

  // slot counter and strobes decoded from the new slot value on each NCEN,
  // so every strobe is aligned with the slot it names
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      slot        <= '0;
      cycle_00    <= 1'b0;
      cycle_17    <= 1'b0;
      cycle_d4    <= 1'b0;
      cycle_d3    <= 1'b0;
      cycle_d3_z  <= 1'b0;
      cycle_d3_zz <= 1'b0;
    end else if (!ncen_n) begin
      slot        <= slot_next;
      cycle_00    <= (slot_next == S_00);
      cycle_17    <= (slot_next == S_LAST);
      cycle_d4    <= (slot_next == S_04);
      cycle_d3    <= (slot_next == S_03);
      cycle_d3_z  <= cycle_d3;
      cycle_d3_zz <= cycle_d3_z;
    end
  end

  // reset stretch: count sample wraps, release on the wrap after RST_HOLD of
  // them so the release coincides with a rising CYCLE_00
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      hold  <= '0;
      rst_n <= 1'b0;
    end else if (!ncen_n && wrap && !rst_n) begin
      if (hold == HOLD_MAX) begin
        rst_n <= 1'b1;
      end else begin
        hold <= hold + HW'(1);
      end
    end
  end

  assign tg.o_phi1_PCEN_n = pcen_n;
  assign tg.o_phi1_NCEN_n = ncen_n;
  assign tg.o_RST_n       = rst_n;
  assign tg.o_CYCLE_00    = cycle_00;
  assign tg.o_CYCLE_17    = cycle_17;
  assign tg.o_CYCLE_D4    = cycle_d4;
  assign tg.o_CYCLE_D3_ZZ = cycle_d3_zz;

`ifdef IKAOPLL_CYCLE_BUS_EN
  assign tg.o_CYCLE_NUM = CYCLE_NUM_W'(slot);
`endif

endmodule

// File: tb/tb_ikaopll_timinggen.sv
// Self-checking bench for ikaopll_timinggen (DIV=4, NSLOT=18, RST_HOLD=2).
// Expected outputs are queued before each clock edge and popped/compared on
// the following falling edge.
module tb_ikaopll_timinggen;

  logic clk;
  logic rst;

  ikaopll_timinggen_if tg();

  ikaopll_timinggen #(
    .DIV      (4),
    .NSLOT    (18),
    .RST_HOLD (2)
  ) dut (
    .i_EMUCLK (clk),
    .i_RST    (rst),
    .tg       (tg.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCEN_n, NCEN_n, RST_n, CYCLE_00, CYCLE_17, CYCLE_D4, CYCLE_D3_ZZ}
  logic [6:0] obs;
  assign obs = {tg.o_phi1_PCEN_n, tg.o_phi1_NCEN_n, tg.o_RST_n, tg.o_CYCLE_00,
                tg.o_CYCLE_17, tg.o_CYCLE_D4, tg.o_CYCLE_D3_ZZ};

  localparam logic [6:0] RST_VALS = 7'b1100000;

  typedef struct {
    logic [6:0] outs;
    logic [4:0] num;
    int         n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rel    = 0;   // emuclk rising edges since the last reset release

  // expected outputs after the n-th rising edge since release
  function automatic logic [6:0] exp_outs(input int n, input int slot,
                                          input bit c00_ok, input bit rstn);
    logic pc;
    logic nc;
    pc = !((n > 0) && (n % 4 == 0));
    nc = !(n % 4 == 2);
    return {pc, nc, rstn, c00_ok && (slot == 0), slot == 17, slot == 4, slot == 5};
  endfunction

  // undisturbed run: the slot advances on edges 3, 7, 11, ...
  function automatic int free_k(input int n);
    return (n + 1) / 4;
  endfunction

  function automatic int free_slot(input int n);
    return free_k(n) % 18;
  endfunction

  // third CYCLE_00 rise after release is at k = 54
  function automatic bit free_rstn(input int n);
    return free_k(n) >= 54;
  endfunction

  // queue an expectation and advance to the sampling point of the next cycle
  task automatic step(input logic [6:0] outs, input int slot);
    exp_t e;
    e.outs = outs;
    e.num  = 5'(slot);
    e.n    = n_rel + 1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    n_rel++;
  endtask

  task automatic test_reset;
    exp_t e;
    tg.i_TEST = 4'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== RST_VALS)
      $display("FAIL reset_async outs actual=%b required=%b", obs, RST_VALS);
    else
      n_pass++;
    for (int i = 0; i < 10; i++) begin
      step(RST_VALS, 0);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.outs)
        $display("FAIL reset_hold cyc=%0d outs actual=%b required=%b", i, obs, e.outs);
      else
        n_pass++;
`ifdef IKAOPLL_CYCLE_BUS_EN
      n_checks++;
      if (tg.o_CYCLE_NUM !== e.num)
        $display("FAIL reset_num cyc=%0d actual=%0d required=%0d", i, tg.o_CYCLE_NUM, e.num);
      else
        n_pass++;
`endif
    end
    rst   = 1'b0;
    n_rel = 0;
  endtask

  // enables, slot strobes, D3 delay and reset stretch over 3+ samples
  task automatic test_free_run;
    exp_t e;
    int   n;
    for (int i = 0; i < 260; i++) begin
      n = n_rel + 1;
      step(exp_outs(n, free_slot(n), free_k(n) > 0, free_rstn(n)), free_slot(n));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.outs)
        $display("FAIL free_run n=%0d outs actual=%b required=%b", e.n, obs, e.outs);
      else
        n_pass++;
`ifdef IKAOPLL_CYCLE_BUS_EN
      n_checks++;
      if (tg.o_CYCLE_NUM !== e.num)
        $display("FAIL free_num n=%0d actual=%0d required=%0d", e.n, tg.o_CYCLE_NUM, e.num);
      else
        n_pass++;
`endif
    end
  endtask

  // TEST[1] set at slot 9: counter held at 0, enables keep running,
  // counting resumes at 1 after release
  task automatic test_cnthold;
    exp_t e;
    int   n;
    int   n_hold;
    int   n_res;
    int   slot;
    int   guard;
    guard = 0;
    while (free_slot(n_rel) != 9 && guard < 100) begin
      n = n_rel + 1;
      step(exp_outs(n, free_slot(n), 1'b1, free_rstn(n)), free_slot(n));
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.outs)
        $display("FAIL hold_pre n=%0d outs actual=%b required=%b", e.n, obs, e.outs);
      else
        n_pass++;
      guard++;
    end
    tg.i_TEST = 4'b0010;
    n_hold = n_rel + 1;
    while (n_hold % 4 != 3) n_hold++;
    for (int i = 0; i < 56; i++) begin
      n = n_rel + 1;
      slot = (n >= n_hold) ? 0 : 9;
      step(exp_outs(n, slot, 1'b1, 1'b1), slot);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.outs)
        $display("FAIL hold_on n=%0d outs actual=%b required=%b", e.n, obs, e.outs);
      else
        n_pass++;
`ifdef IKAOPLL_CYCLE_BUS_EN
      n_checks++;
      if (tg.o_CYCLE_NUM !== e.num)
        $display("FAIL hold_num n=%0d actual=%0d required=%0d", e.n, tg.o_CYCLE_NUM, e.num);
      else
        n_pass++;
`endif
    end
    tg.i_TEST = 4'd0;
    n_res = n_rel + 1;
    while (n_res % 4 != 3) n_res++;
    for (int i = 0; i < 90; i++) begin
      n = n_rel + 1;
      slot = (n < n_res) ? 0 : (((n - n_res) / 4 + 1) % 18);
      step(exp_outs(n, slot, 1'b1, 1'b1), slot);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.outs)
        $display("FAIL hold_resume n=%0d outs actual=%b required=%b", e.n, obs, e.outs);
      else
        n_pass++;
`ifdef IKAOPLL_CYCLE_BUS_EN
      n_checks++;
      if (tg.o_CYCLE_NUM !== e.num)
        $display("FAIL resume_num n=%0d actual=%0d required=%0d", e.n, tg.o_CYCLE_NUM, e.num);
      else
        n_pass++;
`endif
    end
  endtask

  // one-emuclk reset pulses: from normal running, then at slot 12 of the
  // second hold sample; the stretch must restart from zero wraps
  task automatic test_reset_pulse;
    exp_t e;
    int   n;
    for (int p = 0; p < 2; p++) begin
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== RST_VALS)
        $display("FAIL pulse%0d_async outs actual=%b required=%b", p, obs, RST_VALS);
      else
        n_pass++;
      step(RST_VALS, 0);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.outs)
        $display("FAIL pulse%0d_held outs actual=%b required=%b", p, obs, e.outs);
      else
        n_pass++;
`ifdef IKAOPLL_CYCLE_BUS_EN
      n_checks++;
      if (tg.o_CYCLE_NUM !== e.num)
        $display("FAIL pulse%0d_num actual=%0d required=%0d", p, tg.o_CYCLE_NUM, e.num);
      else
        n_pass++;
`endif
      rst   = 1'b0;
      n_rel = 0;
      // first pass stops at k=30 (slot 12, second hold sample); second runs
      // past the expected release at k=54
      for (int i = 0; i < ((p == 0) ? 119 : 230); i++) begin
        n = n_rel + 1;
        step(exp_outs(n, free_slot(n), free_k(n) > 0, free_rstn(n)), free_slot(n));
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.outs)
          $display("FAIL pulse%0d_run n=%0d outs actual=%b required=%b", p, e.n, obs, e.outs);
        else
          n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_cnthold();
    test_reset_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ikaopll_timinggen.md
Name: ikaopll_timinggen

Overview:
Master timing generator for the IKAOPLL core. It divides the emulator master clock into the phi1 positive- and negative-edge clock enables, runs the 18-slot per-sample cycle counter, and decodes the cycle strobes consumed by the LFO, envelope and operator datapaths. It also stretches the external reset into an aligned active-low internal reset, so that every downstream block leaves reset on the same sample boundary.

Parameters:
- DIV, 4, emuclk periods per phi1 period; must be even and >= 2.
- NSLOT, 18, phi1 cycles per sample; the counter runs 0..NSLOT-1.
- RST_HOLD, 2, number of full samples o_RST_n stays low after i_RST is released.

Ports:
- i_EMUCLK  in  1  emulator master clock; all state is updated on its rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_TEST  in  4  test register; bit 1 forces the cycle counter to hold at 0.
- o_phi1_PCEN_n  out  1  phi1 positive-edge enable; active-low, one emuclk wide.
- o_phi1_NCEN_n  out  1  phi1 negative-edge enable; active-low, one emuclk wide.
- o_RST_n  out  1  internal active-low reset for downstream blocks.
- o_CYCLE_00  out  1  high while the slot count is 0.
- o_CYCLE_17  out  1  high while the slot count is NSLOT-1.
- o_CYCLE_D4  out  1  high while the slot count is 4.
- o_CYCLE_D3_ZZ  out  1  count==3 strobe delayed by two phi1 cycles.

Behaviour:
- Reset values (i_RST high, asynchronous):
  - divider = 0, slot = 0, hold counter = 0.
  - o_phi1_PCEN_n = o_phi1_NCEN_n = 1, o_RST_n = 0.
  - All strobes = 0 and the D3 delay pipe is cleared.
- Divider counts 0..DIV-1 and wraps.
  - o_phi1_NCEN_n is driven low as a registered output when the divider is at DIV/2-1.
  - o_phi1_PCEN_n is driven low when the divider is at DIV-1.
  - The two enables are never low in the same emuclk.
- First NCEN after reset release occurs DIV/2 emuclks later.
- Slot counter advances only on NCEN emuclks and wraps from NSLOT-1 to 0.
  - If i_TEST[1]=1 it is held at 0; the divider keeps running.
- Strobes are registered on the same NCEN emuclk as the slot change.
  - Each strobe is high for exactly one phi1 period (DIV emuclks).
  - o_CYCLE_D3_ZZ is a 2-stage shift clocked on NCEN; it rises two phi1 periods after the count==3 strobe.
- Reset stretch:
  - The hold counter increments at each slot wrap (NSLOT-1 to 0) once i_RST is low.
  - o_RST_n rises on the NCEN emuclk on which slot becomes 0, after RST_HOLD wraps.
  - o_RST_n therefore always rises coincident with o_CYCLE_00.
- Re-asserting i_RST at any point (mid-sample, mid-hold) returns all state to reset values immediately.
- i_TEST[1] asserted while o_RST_n=0: the hold counter freezes until the bit is released.
- NSLOT wrap and the hold-counter increment in the same emuclk are a single event; no double count.

Optional Feature:
- Macro IKAOPLL_CYCLE_BUS_EN.
- Defined: adds output o_CYCLE_NUM (5 bits, registered copy of the slot count, reset value 0) for debug taps and the waveform monitor.
- Undefined: the port is absent and the slot counter is internal only. All other behaviour is identical.

Decomposition:
- Shared package ikaopll_pkg holds:
  - localparams for the slot indices (SLOT_00, SLOT_03, SLOT_04, SLOT_LAST).
  - the default DIV and NSLOT values.
  - the TEST bit index constant TEST_CNTHOLD = 1.
- One natural sub-module, ikaopll_clkdiv: the divider plus PCEN/NCEN generation. The slot counter, strobes and reset stretch stay in the top module.

Test Plan:
- Assert i_RST for 10 emuclks, then release:
  - first NCEN low at emuclk 2 after release, PCEN low at emuclk 4, period 4, never overlapping.
- Free run for 3 samples (216 emuclks):
  - o_CYCLE_00 high every 72 emuclks, 4 wide.
  - o_CYCLE_17 directly precedes it.
  - o_CYCLE_D4 one phi1 after count 3.
  - o_CYCLE_D3_ZZ high at slot 5.
- Reset release with RST_HOLD=2:
  - o_RST_n rises exactly on the 3rd o_CYCLE_00 rising edge after release.
  - It is never high before that edge.
- Set i_TEST[1]=1 at slot 9:
  - slot returns to 0 and o_CYCLE_00 stays high while held.
  - Enables keep toggling.
  - On release, counting resumes at 1 on the next NCEN.
- Pulse i_RST for 1 emuclk at slot 12 of the hold period:
  - all outputs return to reset values asynchronously.
  - The hold count restarts from 0.
- With IKAOPLL_CYCLE_BUS_EN defined:
  - o_CYCLE_NUM steps 0..17 and wraps, matching the strobes (0 with o_CYCLE_00, 17 with o_CYCLE_17).
